// File: rtl/device_regs_with_function.sv
// -----------------------------------------------------------------------------
// device_regs_with_function
//
// Four read/write device control registers behind a single-cycle strobe bus.
// The address decode is a combinational function that turns `addr` into a
// one-hot select of REG0..REG3 plus an "unmapped" flag. Offsets 0x0..0x3 are
// mapped. Every other offset, including any offset with a non-zero upper
// address bit, ignores writes and reads back as zero.
//
// Parameters:
//   ADDRWIDTH - width of addr (>= 2, <= 32)
//   DATAWIDTH - width of every register, wr_data and rd_data
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset (clears registers and rd_data)
//   addr     in   register offset for the current access
//   wen      in   write strobe, one write per cycle it is high
//   wr_data  in   write data, qualified by wen
//   ren      in   read strobe, one read per cycle it is high
//   rd_data  out  registered read data, held until the next read or reset
// -----------------------------------------------------------------------------
module device_regs_with_function #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic                 wen,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 ren,
    output logic [DATAWIDTH-1:0] rd_data
);

    localparam int NUM_REGS = 4;

    typedef struct packed {
        logic [NUM_REGS-1:0] sel;       // one-hot select of REG0..REG3
        logic                unmapped;  // offset outside the register map
    } decode_t;

    // Full-width compare. An offset maps only when every bit above bit 1 is
    // zero, so high offsets never alias onto REG0..REG3.
    function automatic decode_t decode(input logic [ADDRWIDTH-1:0] a);
        decode_t d;
        d.sel      = '0;
        d.unmapped = 1'b1;
        if (32'(a) < 32'(NUM_REGS)) begin
            d.sel[a[1:0]] = 1'b1;
            d.unmapped    = 1'b0;
        end
        return d;
    endfunction

    logic [DATAWIDTH-1:0] regs [NUM_REGS];
    decode_t              dec;
    logic [DATAWIDTH-1:0] rd_mux;

    assign dec = decode(addr);

    // Read mux over the pre-write register contents. An unmapped offset
    // selects nothing and yields zero.
    // NOTE: the default assignment at the top of always_comb keeps every path
    // assigned, so no latch is inferred for rd_mux.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec.sel[i]) begin
                rd_mux = regs[i];
            end
        end
    end

    // NOTE: non-blocking assignments make a same-cycle read sample the
    // register before the write lands, so a read never sees write-through.
    // NOTE: these four registers are ordinary flops rather than a RAM, so
    // every entry is reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wen) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (dec.sel[i]) begin
                        regs[i] <= wr_data;
                    end
                end
            end
            if (ren) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_device_regs_with_function.sv
// -----------------------------------------------------------------------------
// tb_device_regs_with_function
//
// Drives directed scenarios for reset, readback, unmapped space, hold,
// simultaneous access and reset mid-operation, followed by random traffic.
// Every cycle, rd_data is compared with a reference model. The model holds
// the register file as a plain array and applies the bus rules directly.
// -----------------------------------------------------------------------------
module tb_device_regs_with_function;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          wen = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          ren = 1'b0;
    logic [DW-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] model_regs [4];
    logic [DW-1:0] model_rd;

    device_regs_with_function #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wen     (wen),
        .wr_data (wr_data),
        .ren     (ren),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Apply one bus cycle. Inputs change 1 time unit after a rising edge,
    // and rd_data is compared 1 time unit after the next rising edge.
    task automatic bus_cycle(input logic r, input logic w, input logic rd,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned ai;
        rst = r; wen = w; ren = rd; addr = a; wr_data = d;
        @(posedge clk);
        ai = 32'(a);
        if (r) begin
            foreach (model_regs[i]) model_regs[i] = '0;
            model_rd = '0;
        end else begin
            if (rd) model_rd = (ai < 4) ? model_regs[ai] : '0;
            if (w && ai < 4) model_regs[ai] = d;
        end
        #1;
        check("model", rd_data, model_rd);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_cycle(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic read(input logic [AW-1:0] a);
        bus_cycle(1'b0, 1'b0, 1'b1, a, '0);
    endtask

    task automatic idle();
        bus_cycle(1'b0, 1'b0, 1'b0, 4'hF, '0);
    endtask

    initial begin
        logic [DW-1:0] wvals [4];
        wvals[0] = 8'hA5; wvals[1] = 8'hA6; wvals[2] = 8'hA7; wvals[3] = 8'hA8;
        foreach (model_regs[i]) model_regs[i] = '0;
        model_rd = '0;

        // Reset and idle
        bus_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("rst_cycle1", rd_data, 8'h00);
        bus_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("rst_cycle2", rd_data, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read(AW'(i));
            check("reset_read", rd_data, 8'h00);
        end

        // Write and readback, with addr parked at 0xF between accesses
        for (int i = 0; i < 4; i++) begin
            write(AW'(i), wvals[i]);
            idle();
            read(AW'(i));
            check("readback", rd_data, wvals[i]);
            idle();
            check("readback_hold", rd_data, wvals[i]);
        end

        // Unmapped space: writes ignored, reads return zero
        write(4'hF, 8'h5A);
        write(4'h4, 8'h3C);
        read(4'hF);
        check("unmapped_F", rd_data, 8'h00);
        read(4'h4);
        check("unmapped_4", rd_data, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read(AW'(i));
            check("no_alias", rd_data, wvals[i]);
        end

        // Hold: rd_data stays put while ren is low
        read(4'h3);
        check("hold_read", rd_data, 8'hA8);
        for (int i = 0; i < 10; i++) begin
            bus_cycle(1'b0, (i == 0), 1'b0, (i == 0) ? 4'h3 : AW'(i), 8'h00);
            check("hold", rd_data, 8'hA8);
        end
        read(4'h3);
        check("hold_after_write", rd_data, 8'h00);

        // Simultaneous read and write: the read returns the old value
        bus_cycle(1'b0, 1'b1, 1'b1, 4'h1, 8'h11);
        check("simul_old", rd_data, 8'hA6);
        read(4'h1);
        check("simul_new", rd_data, 8'h11);

        // Reset mid-operation overrides a same-cycle write
        write(4'h2, 8'h77);
        bus_cycle(1'b1, 1'b1, 1'b0, 4'h2, 8'hFF);
        check("mid_rst", rd_data, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read(AW'(i));
            check("mid_rst_read", rd_data, 8'h00);
        end

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            bus_cycle(($urandom_range(0, 39) == 0),
                      1'($urandom),
                      1'($urandom),
                      ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3)),
                      DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
